// File: rtl/pbus_pkg.sv
// Shared constants for the peripheral-page Wishbone initiator.
package pbus_pkg;

  localparam int PBUS_ADDR_W = 10;
  localparam int PBUS_DATA_W = 8;
  localparam logic [7:0] PBUS_ERR_DATA = 8'hFF;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

endpackage

// File: rtl/pbus_wb_master.sv
// Single-beat CPU load/store to classic Wishbone initiator.
// PBUS_TIMEOUT_EN compiles in the ack timeout counter and err path.
module pbus_wb_master
  import pbus_pkg::*;
#(
  parameter int ADDR_W = PBUS_ADDR_W,
  parameter int DATA_W = PBUS_DATA_W,
  parameter int TIMEOUT = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = PBUS_ERR_DATA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] WB_ADRo,
  output logic [DATA_W-1:0] WB_DATo,
  input  logic [DATA_W-1:0] WB_DATi,
  output logic              WB_WEo,
  output logic              WB_CYCo,
  output logic              WB_STBo,
  input  logic              WB_ACKi
);

  logic [1:0] state;
  logic       cyc;

  assign ready   = (state != S_ACTIVE);
  assign WB_CYCo = cyc;
  assign WB_STBo = cyc;

`ifdef PBUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;
  logic          err_q;

  assign err = err_q;
`else
  logic unused_cfg;

  assign err        = 1'b0;
  assign unused_cfg = (^ERR_DATA) ^ (TIMEOUT > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cyc     <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      WB_WEo  <= 1'b0;
      WB_ADRo <= '0;
      WB_DATo <= '0;
`ifdef PBUS_TIMEOUT_EN
      cnt     <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
`ifdef PBUS_TIMEOUT_EN
          err_q <= 1'b0;
`endif
          if (req) begin
            state   <= S_ACTIVE;
            cyc     <= 1'b1;
            WB_WEo  <= we;
            WB_ADRo <= addr;
            WB_DATo <= wdata;
`ifdef PBUS_TIMEOUT_EN
            cnt     <= '0;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACTIVE: begin
          // ack takes priority over a coincident timeout expiry
          if (WB_ACKi) begin
            state <= S_DONE;
            cyc   <= 1'b0;
            done  <= 1'b1;
            if (!WB_WEo) rdata <= WB_DATi;
`ifdef PBUS_TIMEOUT_EN
            err_q <= 1'b0;
          end else if (cnt == LAST) begin
            state <= S_DONE;
            cyc   <= 1'b0;
            done  <= 1'b1;
            err_q <= 1'b1;
            if (!WB_WEo) rdata <= ERR_DATA;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        default: begin
          state <= S_IDLE;
          cyc   <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pbus_wb_master.sv
// Randomized self-checking bench for pbus_wb_master.
module tb_pbus_wb_master;

`ifdef PBUS_TIMEOUT_EN
  localparam int TO_LIMIT = 15;
`else
  localparam int TO_LIMIT = 1000000;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [9:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       ready, done, err;
  logic [7:0] rdata;
  logic [9:0] wb_adr;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i = '0;
  logic       wb_we, wb_cyc, wb_stb;
  logic       wb_ack = 1'b0;

  int tests = 0;
  int failures = 0;
  logic [7:0] exp_rdata = 8'h00;

  always #5 clk = ~clk;

  pbus_wb_master dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .WB_ADRo(wb_adr), .WB_DATo(wb_dat_o),
    .WB_DATi(wb_dat_i), .WB_WEo(wb_we), .WB_CYCo(wb_cyc),
    .WB_STBo(wb_stb), .WB_ACKi(wb_ack)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({ready, done, err, wb_cyc, wb_stb, wb_we} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_ctl got %b want 100000",
               {ready, done, err, wb_cyc, wb_stb, wb_we});
    end
    tests++;
    if ({rdata, wb_adr, wb_dat_o} !== 26'd0) begin
      failures++;
      $display("FAIL reset_data got %h/%h/%h want 0", rdata, wb_adr, wb_dat_o);
    end
    rst = 1'b0;
    exp_rdata = 8'h00;
  endtask

  // wait_n < 0: slave never acks; otherwise ack in ACTIVE cycle wait_n+1
  task automatic run_txn(input logic w, input logic [9:0] a,
                         input logic [7:0] d, input int wait_n,
                         input logic [7:0] bd, input string nm);
    int  k;
    int  exp_cycles;
    bit  acked;
    acked = (wait_n >= 0) && (wait_n + 1 <= TO_LIMIT);
    exp_cycles = acked ? wait_n + 1 : TO_LIMIT;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    tests++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready got %b want 1", nm, ready);
    end
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'($urandom); addr = 10'($urandom); wdata = 8'($urandom);
    k = 0;
    while (wb_cyc === 1'b1 && k < 300) begin
      k++;
      tests++;
      if ({wb_stb, wb_we, wb_adr, wb_dat_o, done, ready}
          !== {1'b1, w, a, d, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL %s active_c%0d got stb%b we%b a%h d%h done%b rdy%b want we%b a%h d%h",
                 nm, k, wb_stb, wb_we, wb_adr, wb_dat_o, done, ready, w, a, d);
      end
      if (k == wait_n + 1) begin
        wb_ack = 1'b1; wb_dat_i = bd;
      end else begin
        wb_ack = 1'b0; wb_dat_i = 8'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      wb_ack = 1'b0;
    end
    if (!w) exp_rdata = acked ? bd : 8'hFF;
    tests++;
    if (k !== exp_cycles) begin
      failures++;
      $display("FAIL %s cyc_len got %0d want %0d", nm, k, exp_cycles);
    end
    tests++;
    if ({done, err, ready, wb_cyc} !== {1'b1, !acked, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL %s done_err got d%b e%b r%b c%b want d1 e%b r1 c0",
               nm, done, err, ready, wb_cyc, !acked);
    end
    tests++;
    if (rdata !== exp_rdata) begin
      failures++;
      $display("FAIL %s rdata got %h want %h", nm, rdata, exp_rdata);
    end
  endtask

  task automatic test_zero_wait_read();
    run_txn(1'b0, 10'h012, 8'h00, 0, 8'h5A, "zw_read");
  endtask

  task automatic test_wait_write();
    run_txn(1'b1, 10'h040, 8'hC3, 3, 8'h99, "wait3_write");
  endtask

  task automatic test_ack_ignored();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wb_ack = 1'b1; wb_dat_i = 8'h77;
      @(posedge clk);
      @(negedge clk);
      wb_ack = 1'b0;
      tests++;
      if ({done, wb_cyc, rdata} !== {2'b00, exp_rdata}) begin
        failures++;
        $display("FAIL ack_idle got d%b c%b r%h want d0 c0 r%h",
                 done, wb_cyc, rdata, exp_rdata);
      end
    end
  endtask

  task automatic test_timeout();
`ifdef PBUS_TIMEOUT_EN
    run_txn(1'b0, 10'h100, 8'h00, -1, 8'h00, "timeout_read");
    run_txn(1'b0, 10'h101, 8'h00, 14, 8'h3C, "ack_at_last");
    run_txn(1'b1, 10'h102, 8'hAB, -1, 8'h00, "timeout_write");
`else
    run_txn(1'b0, 10'h100, 8'h00, 120, 8'h3C, "long_wait");
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] bdata [3];
    int done_at [3];
    int nacc, ndone;
    for (int i = 0; i < 3; i++) bdata[i] = 8'($urandom);
    nacc = 0; ndone = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 10'($urandom);
    for (int c = 0; c < 12; c++) begin
      wb_ack = wb_cyc;
      wb_dat_i = (wb_cyc && nacc > 0) ? bdata[nacc-1] : 8'($urandom);
      if (done === 1'b1) begin
        tests++;
        if (ndone < 3) begin
          done_at[ndone] = c;
          if ({wb_cyc, rdata} !== {1'b0, bdata[ndone]}) begin
            failures++;
            $display("FAIL b2b_beat%0d got c%b r%h want c0 r%h",
                     ndone, wb_cyc, rdata, bdata[ndone]);
          end
        end else begin
          failures++;
          $display("FAIL b2b_extra_done got %0d want 3", ndone + 1);
        end
        ndone++;
      end
      if (req && ready) nacc++;
      @(posedge clk);
      @(negedge clk);
      addr = 10'($urandom);
      if (nacc == 3) req = 1'b0;
    end
    wb_ack = 1'b0;
    exp_rdata = bdata[2];
    tests++;
    if (ndone !== 3) begin
      failures++;
      $display("FAIL b2b_count got %0d want 3", ndone);
    end else begin
      tests++;
      if (done_at[0] !== 2 || done_at[1] !== 4 || done_at[2] !== 6) begin
        failures++;
        $display("FAIL b2b_spacing got %0d,%0d,%0d want 2,4,6",
                 done_at[0], done_at[1], done_at[2]);
      end
    end
  endtask

  task automatic test_random();
    int wn;
    for (int i = 0; i < 20; i++) begin
`ifdef PBUS_TIMEOUT_EN
      wn = $urandom_range(0, 18);
`else
      wn = $urandom_range(0, 6);
`endif
      run_txn(1'($urandom), 10'($urandom), 8'($urandom), wn,
              8'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 10'h3F0;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = 8'h00;
    tests++;
    if ({wb_cyc, wb_stb, ready, done, rdata} !== {4'b0010, 8'h00}) begin
      failures++;
      $display("FAIL rst_mid got c%b s%b r%b d%b rd%h want c0 s0 r1 d0 rd00",
               wb_cyc, wb_stb, ready, done, rdata);
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_nodone got %b want 0", done);
    end
    run_txn(1'b0, 10'h0A5, 8'h00, 1, 8'hE7, "after_rst");
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_ack_ignored();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
